// File: rtl/voq_pkg.sv
// Shared types for the per-input virtual output queues and the VOQ picker.
package voq_pkg;
  localparam int NUM_VOQ = 4;
  typedef logic [1:0] voq_id_t;
  typedef logic [3:0] voq_mask_t;
endpackage

// File: rtl/voq_ptr.sv
// Pointer/occupancy bookkeeping for one VOQ. The caller only asserts push when
// not full and pop when not empty, so this block never over- or under-flows.
module voq_ptr #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty_q, full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from the post-update count so they describe the
  // queue as it stands at the start of the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_FULL);
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign empty_o  = empty_q;
  assign full_o   = full_q;
endmodule

// File: rtl/voq_writer.sv
// Enqueue side of the per-input VOQs: shared descriptor array split into four
// circular queues, accept/drop decision, registered head read and drop counter.
module voq_writer
  import voq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  input  voq_id_t           enq_dest,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq_en,
  input  voq_id_t           deq_sel,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  output voq_mask_t         voq_empty,
  output voq_mask_t         voq_full,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ADDR_W = $bits(voq_id_t) + PTR_W;

  logic [PTR_W-1:0]  wr_ptr [NUM_VOQ];
  logic [PTR_W-1:0]  rd_ptr [NUM_VOQ];
  voq_mask_t         push, pop, empty_vec, full_vec;
  logic              enq_accept, enq_drop, deq_accept;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  logic [DATA_W-1:0] mem_q [NUM_VOQ*DEPTH];
  logic              deq_valid_q;
  logic [DATA_W-1:0] deq_data_q;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Decisions use the registered flags, i.e. occupancy at the start of the cycle.
  assign enq_accept = enq_valid && !full_vec[enq_dest];
  assign enq_drop   = enq_valid &&  full_vec[enq_dest];
  assign deq_accept = deq_en    && !empty_vec[deq_sel];

  generate
    for (genvar gi = 0; gi < NUM_VOQ; gi++) begin : g_voq
      assign push[gi] = enq_accept && (enq_dest == voq_id_t'(gi));
      assign pop[gi]  = deq_accept && (deq_sel  == voq_id_t'(gi));

      voq_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .push_i   (push[gi]),
        .pop_i    (pop[gi]),
        .wr_ptr_o (wr_ptr[gi]),
        .rd_ptr_o (rd_ptr[gi]),
        .empty_o  (empty_vec[gi]),
        .full_o   (full_vec[gi])
      );
    end
  endgenerate

  assign wr_addr = {enq_dest, wr_ptr[enq_dest]};
  assign rd_addr = {deq_sel,  rd_ptr[deq_sel]};

  always_ff @(posedge clk) begin
    if (enq_accept) mem_q[wr_addr] <= enq_data;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (enq_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      deq_valid_q <= deq_accept;
      if (deq_accept) deq_data_q <= mem_q[rd_addr];
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign deq_valid = deq_valid_q;
  assign deq_data  = deq_data_q;
  assign voq_empty = empty_vec;
  assign voq_full  = full_vec;
  assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_voq_writer.sv
// Self-checking bench for voq_writer: directed scenarios plus random traffic
// compared against four plain FIFO queues.
module tb_voq_writer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              enq_valid;
  logic [1:0]        enq_dest;
  logic [DATA_W-1:0] enq_data;
  logic              deq_en;
  logic [1:0]        deq_sel;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic [3:0]        voq_empty;
  logic [3:0]        voq_full;
  logic [CNT_W-1:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mq [4][$];
  logic [DATA_W-1:0] m_last;
  logic [CNT_W-1:0]  m_drop;

  voq_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_dest  (enq_dest),
    .enq_data  (enq_data),
    .deq_en    (deq_en),
    .deq_sel   (deq_sel),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .voq_empty (voq_empty),
    .voq_full  (voq_full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_empty();
    logic [3:0] m;
    for (int q = 0; q < 4; q++) m[q] = (mq[q].size() == 0);
    return m;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] m;
    for (int q = 0; q < 4; q++) m[q] = (mq[q].size() == DEPTH);
    return m;
  endfunction

  // One clock of stimulus; the model applies the queue rules using occupancy
  // at the start of the cycle, then every output is compared after the edge.
  task automatic step(input bit ev, input logic [1:0] ed, input logic [DATA_W-1:0] edata,
                      input bit de, input logic [1:0] ds);
    bit was_full, was_empty, exp_v;
    enq_valid = ev;
    enq_dest  = ed;
    enq_data  = edata;
    deq_en    = de;
    deq_sel   = ds;
    was_full  = (mq[ed].size() == DEPTH);
    was_empty = (mq[ds].size() == 0);
    exp_v     = de && !was_empty;
    if (exp_v) m_last = mq[ds].pop_front();
    if (ev) begin
      if (was_full) begin
        if (m_drop != '1) m_drop++;
      end else begin
        mq[ed].push_back(edata);
      end
    end
    @(posedge clk);
    #1;
    check("deq_valid", {31'd0, deq_valid}, {31'd0, exp_v});
    check("deq_data", deq_data, m_last);
    check("voq_empty", {28'd0, voq_empty}, {28'd0, model_empty()});
    check("voq_full", {28'd0, voq_full}, {28'd0, model_full()});
    check("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
    if (exp_v) $display("pop q%0d -> 0x%08h", ds, deq_data);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  task automatic model_reset();
    for (int q = 0; q < 4; q++) mq[q].delete();
    m_last = '0;
    m_drop = '0;
  endtask

  initial begin
    reset = 1'b1;
    enq_valid = 1'b0; enq_dest = '0; enq_data = '0; deq_en = 1'b0; deq_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    check("rst_empty", {28'd0, voq_empty}, 32'hF);
    check("rst_full", {28'd0, voq_full}, 32'h0);
    check("rst_deq_valid", {31'd0, deq_valid}, 32'h0);
    check("rst_drop", {16'd0, drop_cnt}, 32'h0);
    idle();

    // Single enqueue/pop on VOQ 2
    step(1'b1, 2'd2, 32'hA1, 1'b0, 2'd0);
    check("enq_a1_empty", {28'd0, voq_empty}, 32'b1011);
    step(1'b0, 2'd0, '0, 1'b1, 2'd2);
    check("pop_a1_data", deq_data, 32'hA1);
    check("pop_a1_empty", {28'd0, voq_empty}, 32'hF);
    idle();

    // Fill VOQ 1 and overflow once
    for (int i = 0; i < 9; i++) step(1'b1, 2'd1, 32'h10 + i, 1'b0, 2'd0);
    check("fill_full", {28'd0, voq_full}, 32'b0010);
    check("fill_drop", {16'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd1);
    check("drain_last", deq_data, 32'h17);
    step(1'b0, 2'd0, '0, 1'b1, 2'd1);

    // Pointer wrap on VOQ 0
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'd0, i, 1'b0, 2'd0);
      step(1'b0, 2'd0, '0, 1'b1, 2'd0);
      check("wrap_data", deq_data, i);
    end

    // Simultaneous enqueue and pop on VOQ 3
    step(1'b1, 2'd3, 32'h55, 1'b0, 2'd0);
    step(1'b1, 2'd3, 32'h66, 1'b1, 2'd3);
    check("same_q_data", deq_data, 32'h55);
    step(1'b0, 2'd0, '0, 1'b1, 2'd3);
    step(1'b1, 2'd3, 32'h77, 1'b1, 2'd3);
    check("empty_same_valid", {31'd0, deq_valid}, 32'h0);
    check("empty_same_e3", {31'd0, voq_empty[3]}, 32'h0);
    step(1'b0, 2'd0, '0, 1'b1, 2'd3);

    // Asynchronous reset with data queued and a pop pending
    step(1'b1, 2'd0, 32'hC0, 1'b0, 2'd0);
    step(1'b1, 2'd0, 32'hC1, 1'b0, 2'd0);
    step(1'b1, 2'd2, 32'hC2, 1'b1, 2'd0);
    step(1'b0, 2'd0, '0, 1'b1, 2'd0);
    enq_valid = 1'b0; deq_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_empty", {28'd0, voq_empty}, 32'hF);
    check("async_valid", {31'd0, deq_valid}, 32'h0);
    check("async_data", deq_data, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 2'd0, '0, 1'b1, 2'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, 2'($urandom_range(0, 3)), $urandom,
           ($urandom % 2) != 0, 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 40; i++) step(1'b0, 2'd0, '0, 1'b1, 2'(i % 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
